// File: rtl/freq_id_pkg.sv
// Shared types and constants for the processor frequency-ID decoder.
// Bit positions describe the layout of the 32-bit procFreqId word.
package freq_id_pkg;

    localparam int DIGITS = 6;
    localparam int FREQ_W = 20;
    localparam int IDX_W  = 3;

    localparam int FREQ_MSB  = 31;
    localparam int FREQ_LSB  = 8;
    localparam int RSVD_BIT  = 7;
    localparam int PROCS_MSB = 6;
    localparam int PROCS_LSB = 4;
    localparam int BIOS_BIT  = 3;
    localparam int ID_MSB    = 2;
    localparam int ID_LSB    = 0;

    typedef enum logic {
        IDLE,
        CONVERT
    } FsmState;

    // Digit 5 is the most significant nibble of the 24-bit field.
    function automatic logic [3:0] digitAt(input logic [4*DIGITS-1:0] field,
                                           input logic [IDX_W-1:0] idx);
        return 4'(field >> {idx, 2'b00});
    endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal accumulation step: accOut = accIn*10 + digit, flagging non-BCD digits.
module bcd_mac_step
    import freq_id_pkg::*;
(
    input  logic [FREQ_W-1:0] accIn,
    input  logic [3:0]        digit,
    output logic [FREQ_W-1:0] accOut,
    output logic              digitError
);

    // The largest six-digit value still fits in FREQ_W bits, so no overflow.
    assign accOut     = (accIn << 3) + (accIn << 1) + {{(FREQ_W-4){1'b0}}, digit};
    assign digitError = (digit > 4'd9);

endmodule

// File: rtl/freq_id_decoder.sv
// Decodes the processor-ID word: registers the static fields and converts
// the six-digit BCD kHz field to binary, one digit per clock.
module freq_id_decoder
    import freq_id_pkg::*;
#(
    parameter int MIN_KHZ = 1000,
    parameter int MAX_KHZ = 100000
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       procFreqId,
    output logic [FREQ_W-1:0] freqKhz,
    output logic              freqValid,
    output logic              freqUpdate,
    output logic              freqInRange,
    output logic              bcdError,
    output logic [2:0]        procId,
    output logic [2:0]        nrOfProcs,
    output logic              biosEnabled
);

    localparam logic [FREQ_W-1:0] MIN_VAL  = FREQ_W'(MIN_KHZ);
    localparam logic [FREQ_W-1:0] MAX_VAL  = FREQ_W'(MAX_KHZ);
    localparam logic [IDX_W-1:0]  TOP_DIGIT = IDX_W'(DIGITS - 1);

    FsmState                 state;
    FsmState                 nextState;
    logic [4*DIGITS-1:0]     snapshot;
    logic [FREQ_W-1:0]       acc;
    logic [IDX_W-1:0]        index;
    logic [4*DIGITS-1:0]     freqField;
    logic [3:0]              digit;
    logic [FREQ_W-1:0]       accNext;
    logic                    digitError;
    logic                    loadSnap;
    logic                    finishOk;
    logic                    abortErr;
    logic                    inRangeNext;
    logic                    unusedReserved;

    assign freqField      = procFreqId[FREQ_MSB:FREQ_LSB];
    assign digit          = digitAt(snapshot, index);
    assign inRangeNext    = (accNext >= MIN_VAL) && (accNext <= MAX_VAL);
    assign unusedReserved = procFreqId[RSVD_BIT];

    bcd_mac_step macStep (
        .accIn      (acc),
        .digit      (digit),
        .accOut     (accNext),
        .digitError (digitError)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            procId      <= '0;
            nrOfProcs   <= '0;
            biosEnabled <= 1'b0;
        end else begin
            procId      <= procFreqId[ID_MSB:ID_LSB];
            nrOfProcs   <= procFreqId[PROCS_MSB:PROCS_LSB];
            biosEnabled <= procFreqId[BIOS_BIT];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A changed field is only noticed in IDLE, so edits mid-conversion wait their turn.
    always_comb begin
        nextState = state;
        loadSnap  = 1'b0;
        finishOk  = 1'b0;
        abortErr  = 1'b0;
        case (state)
            IDLE: begin
                if (freqField != snapshot) begin
                    loadSnap  = 1'b1;
                    nextState = CONVERT;
                end
            end
            CONVERT: begin
                if (digitError) begin
                    abortErr  = 1'b1;
                    nextState = IDLE;
                end else if (index == '0) begin
                    finishOk  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snapshot    <= '0;
            acc         <= '0;
            index       <= '0;
            freqKhz     <= '0;
            freqValid   <= 1'b0;
            freqUpdate  <= 1'b0;
            freqInRange <= 1'b0;
            bcdError    <= 1'b0;
        end else begin
            freqUpdate <= 1'b0;
            if (loadSnap) begin
                snapshot <= freqField;
                acc      <= '0;
                index    <= TOP_DIGIT;
            end else if (state == CONVERT) begin
                acc   <= accNext;
                index <= index - 1'b1;
                if (abortErr) begin
                    bcdError    <= 1'b1;
                    freqValid   <= 1'b0;
                    freqInRange <= 1'b0;
                end else if (finishOk) begin
                    freqKhz     <= accNext;
                    freqValid   <= 1'b1;
                    freqInRange <= inRangeNext;
                    bcdError    <= 1'b0;
                    freqUpdate  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_id_decoder.sv
// Scoreboard bench for freq_id_decoder: stimulus queues expected conversion
// results, a negedge monitor compares them when the DUT reports an event.
module tb_freq_id_decoder;

    logic        clock;
    logic        reset;
    logic [31:0] procFreqId;
    logic [19:0] freqKhz;
    logic        freqValid;
    logic        freqUpdate;
    logic        freqInRange;
    logic        bcdError;
    logic [2:0]  procId;
    logic [2:0]  nrOfProcs;
    logic        biosEnabled;

    typedef struct {
        int unsigned cycleDue;
        logic [19:0] khz;
        logic        valid;
        logic        inRange;
        logic        err;
        logic [2:0]  id;
        logic [2:0]  procs;
        logic        bios;
    } Expect;

    Expect       sb[$];
    int unsigned cycle       = 0;
    int unsigned checks      = 0;
    int unsigned errors      = 0;
    int unsigned updateCount = 0;
    logic        prevErr     = 1'b0;

    freq_id_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .procFreqId  (procFreqId),
        .freqKhz     (freqKhz),
        .freqValid   (freqValid),
        .freqUpdate  (freqUpdate),
        .freqInRange (freqInRange),
        .bcdError    (bcdError),
        .procId      (procId),
        .nrOfProcs   (nrOfProcs),
        .biosEnabled (biosEnabled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [19:0] khz, input logic valid,
                               input logic upd, input logic inRange, input logic err,
                               input logic [2:0] id, input logic [2:0] procs, input logic bios);
        check({tag, ".freqKhz"},     32'(freqKhz),     32'(khz));
        check({tag, ".freqValid"},   32'(freqValid),   32'(valid));
        check({tag, ".freqUpdate"},  32'(freqUpdate),  32'(upd));
        check({tag, ".freqInRange"}, 32'(freqInRange), 32'(inRange));
        check({tag, ".bcdError"},    32'(bcdError),    32'(err));
        check({tag, ".procId"},      32'(procId),      32'(id));
        check({tag, ".nrOfProcs"},   32'(nrOfProcs),   32'(procs));
        check({tag, ".biosEnabled"}, 32'(biosEnabled), 32'(bios));
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        @(negedge clock);
        procFreqId = word;
    endtask

    task automatic pushExpect(input int unsigned due, input logic [19:0] khz, input logic valid,
                              input logic inRange, input logic err, input logic [2:0] id,
                              input logic [2:0] procs, input logic bios);
        Expect e;
        e.cycleDue = due;
        e.khz      = khz;
        e.valid    = valid;
        e.inRange  = inRange;
        e.err      = err;
        e.id       = id;
        e.procs    = procs;
        e.bios     = bios;
        sb.push_back(e);
    endtask

    // An event is a completed conversion or a freshly raised BCD error.
    always @(negedge clock) begin
        Expect e;
        if (reset) begin
            if (freqUpdate) updateCount++;
            if (freqUpdate || (bcdError && !prevErr)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent actual=freqUpdate %0d bcdError %0d required=no event (cycle %0d)",
                             freqUpdate, bcdError, cycle);
                end else begin
                    e = sb.pop_front();
                    check("event.cycle",       cycle,              e.cycleDue);
                    check("event.freqKhz",     32'(freqKhz),       32'(e.khz));
                    check("event.freqValid",   32'(freqValid),     32'(e.valid));
                    check("event.freqInRange", 32'(freqInRange),   32'(e.inRange));
                    check("event.bcdError",    32'(bcdError),      32'(e.err));
                    check("event.procId",      32'(procId),        32'(e.id));
                    check("event.nrOfProcs",   32'(nrOfProcs),     32'(e.procs));
                    check("event.biosEnabled", 32'(biosEnabled),   32'(e.bios));
                end
            end
            prevErr = bcdError;
        end else begin
            prevErr = 1'b0;
        end
    end

    initial begin
        int unsigned c;
        int unsigned u0;
        reset      = 1'b0;
        procFreqId = 32'h0;
        #3;
        checkOutput("reset", 20'd0, 0, 0, 0, 0, 3'd0, 3'd0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // An all-zero field matches the reset snapshot, so nothing converts.
        repeat (5) @(negedge clock);
        checkOutput("zeroField", 20'd0, 0, 0, 0, 0, 3'd0, 3'd0, 0);

        // Load edge plus six digit edges: result visible seven cycles after driving.
        applyStimulus(32'h05000011);
        pushExpect(cycle + 7, 20'd50000, 1, 1, 0, 3'd1, 3'd1, 0);
        repeat (10) @(negedge clock);

        // The second digit (0xA) aborts on the third edge after driving.
        applyStimulus(32'h0A000011);
        pushExpect(cycle + 3, 20'd50000, 0, 0, 1, 3'd1, 3'd1, 0);
        repeat (10) @(negedge clock);
        checkOutput("afterBcdError", 20'd50000, 0, 0, 0, 1, 3'd1, 3'd1, 0);

        applyStimulus(32'h99999909);
        pushExpect(cycle + 7, 20'd999999, 1, 0, 0, 3'd1, 3'd0, 1);
        @(negedge clock);
        checkOutput("fieldLatency", 20'd50000, 0, 0, 0, 1, 3'd1, 3'd0, 1);
        repeat (10) @(negedge clock);

        // The mid-conversion change is picked up on the idle edge right after the first pulse.
        applyStimulus(32'h05000011);
        c = cycle;
        pushExpect(c + 7, 20'd50000, 1, 1, 0, 3'd1, 3'd1, 0);
        repeat (3) @(negedge clock);
        procFreqId = 32'h04800011;
        pushExpect(c + 14, 20'd48000, 1, 1, 0, 3'd1, 3'd1, 0);
        repeat (20) @(negedge clock);

        applyStimulus(32'h05000011);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midReset", 20'd0, 0, 0, 0, 0, 3'd0, 3'd0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pushExpect(cycle + 7, 20'd50000, 1, 1, 0, 3'd1, 3'd1, 0);
        repeat (15) @(negedge clock);

        u0 = updateCount;
        repeat (1000) @(negedge clock);
        check("holdNoUpdate", updateCount - u0, 0);
        checkOutput("afterHold", 20'd50000, 1, 0, 1, 0, 3'd1, 3'd1, 0);

        check("scoreboardEmpty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
